data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Memory-side responder for the processor's data-memory interface. The processor issues Rd/Wr requests; this block serves them with configurable multi-cycle latency.
- Handshake: Stall while busy, a one-cycle Done pulse on completion.
- Holds the backing 16-bit word array and flags illegal requests on err.
- Sits between the memory stage and the storage; the multi-cycle pipeline will stall on it.

Parameters:
- DEPTH_LOG2, 8, log2 of number of 16-bit words in the array (default 256 words).
- LATENCY, 2, WAIT cycles between acceptance and the Done cycle; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- Addr  input  16  byte address; bit 0 must be 0.
- DataIn  input  16  write data.
- Rd  input  1  read request.
- Wr  input  1  write request.
- DataOut  output  16  read data, valid in Done cycle of a read.
- Done  output  1  one-cycle completion pulse.
- Stall  output  1  responder busy; new requests ignored.
- err  output  1  one-cycle pulse for an illegal request.

Behaviour:
- Reset values (rst=0, asynchronous): state=IDLE, Done=0, Stall=0, err=0, DataOut=16'h0000, latched request cleared, wait counter=0.
- Array contents are not reset.
- A reset mid-operation drops the in-flight request; a pending write is never performed.
- FSM states: IDLE, WAIT, RESP.
- Stall = (state==WAIT). Done = (state==RESP), registered.
- Acceptance happens on a rising edge with state in {IDLE, RESP} and exactly one of Rd/Wr high and Addr[0]==0. It:
  - latches op, Addr[DEPTH_LOG2:1] and DataIn;
  - loads counter=LATENCY-1;
  - moves to WAIT.
- An illegal request (Rd&Wr both high, or (Rd|Wr)&Addr[0]) in IDLE/RESP:
  - is not accepted;
  - sets err=1 for the next cycle only;
  - state goes to IDLE.
- Requests presented during WAIT are ignored entirely (no err, no effect). The initiator must hold its request until it sees Stall low.
- WAIT: counter decrements each cycle. When counter==0, the next edge enters RESP. WAIT therefore lasts exactly LATENCY cycles.
- On the edge entering RESP:
  - a write stores the latched data to array[latched index];
  - a read loads DataOut from array[latched index].
- RESP lasts one cycle (Done=1). It returns to IDLE unless a new legal request is accepted in that same cycle (back-to-back).
- Timing for a request accepted at edge T:
  - WAIT covers cycles T+1..T+LATENCY;
  - Done is high in cycle T+LATENCY+1;
  - peak throughput is one request per LATENCY+1 cycles.
- DataOut holds its last read value through writes and idle cycles. It updates only on read completion.
- Address aliasing: Addr bits above DEPTH_LOG2 are ignored, so the index wraps modulo 2^DEPTH_LOG2.
- Ordering: a read accepted after a write's Done returns the written data. No reordering; at most one request in flight.
- No combinational path from Rd/Wr/Addr to any output.

Test Plan:
- Reset: hold rst=0 with Rd=1 → Done=0, Stall=0, err=0, DataOut=0. Release rst, write Addr=16'h0010 DataIn=16'hBEEF (LATENCY=2) accepted at T → Stall=1 in T+1,T+2; Done=1 in T+3 only.
- Read-after-write: read Addr=16'h0010 after previous Done → Done at T+3, DataOut=16'hBEEF, held afterwards through an idle period.
- Illegal: Rd=Wr=1, and separately Rd=1 with Addr=16'h0011 → err=1 for exactly one cycle, no Stall, no Done; a later read of 16'h0010 still returns 16'hBEEF.
- Back-to-back: present a read of 16'h0010 in the RESP cycle of a prior write to 16'h0020=16'h1234 → accepted without an IDLE gap. Then read 16'h0020 → 16'h1234. Wrap: DEPTH_LOG2=8, write 16'h0202=16'hAAAA → read 16'h0002 returns 16'hAAAA.
- Stall ignore: toggle Wr with DataIn=16'hDEAD to 16'h0030 during WAIT of a read → no write occurs; 16'h0030 retains its old value.
- Mid-op reset: assert rst during WAIT of a write of 16'h5555 to 16'h0040 → all outputs are 0 immediately (asynchronous); after release, reading 16'h0040 returns its pre-write value. Repeat the basic write/read with LATENCY=1 → Done at T+2.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data-memory responder with Stall/Done handshake and illegal-request flag
// Ports: clk, rst (async, active-low); Addr/DataIn/Rd/Wr request inputs;
//        DataOut read data (valid in Done cycle, held otherwise); Done completion pulse;
//        Stall busy (requests ignored); err one-cycle pulse after an illegal request.
module data_mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        err
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  localparam logic [3:0] LOAD = 4'(LATENCY - 1);
  logic [1:0] state;
  logic [3:0] cnt;
  logic op_wr;
  logic [DEPTH_LOG2-1:0] idx;
  logic [15:0] wdata;
  logic [15:0] mem [2**DEPTH_LOG2];
  logic open, accept, illegal, finish;
  // high address bits alias away; the name keeps lint from flagging them
  logic unused_addr;
  assign unused_addr = ^Addr[15:DEPTH_LOG2+1];
  always_comb begin
    open    = state != WAIT;
    accept  = open & (Rd ^ Wr) & ~Addr[0];
    illegal = open & ((Rd & Wr) | ((Rd | Wr) & Addr[0]));
    finish  = (state == WAIT) && (cnt == 4'd0);
  end
  assign Stall = state == WAIT;
  assign Done  = state == RESP;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      op_wr   <= 1'b0;
      idx     <= '0;
      wdata   <= 16'h0000;
      err     <= 1'b0;
      DataOut <= 16'h0000;
    end else begin
      err <= illegal;
      if (state == WAIT) begin
        state <= finish ? RESP : WAIT;
        cnt   <= finish ? cnt : cnt - 4'd1;
        if (finish && !op_wr) DataOut <= mem[idx];
      end else if (accept) begin
        state <= WAIT;
        cnt   <= LOAD;
        op_wr <= Wr;
        idx   <= Addr[DEPTH_LOG2:1];
        wdata <= DataIn;
      end else
        state <= IDLE;
    end
  // reset forces state to IDLE asynchronously, so an aborted write never reaches here
  always_ff @(posedge clk)
    if (finish && op_wr) mem[idx] <= wdata;
endmodule
